// File: rtl/voice_scheduler_pkg.sv
// Shared types and constants for the voice scheduler.
// State encoding, default voice count and slot-phase values.
package voice_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVENT = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam int NUM_VOICES_DEF = 16;

  localparam logic PH_READ    = 1'b0;
  localparam logic PH_COMPUTE = 1'b1;

endpackage

// File: rtl/voice_scheduler_if.sv
// Note-event valid/ready channel into the voice scheduler.
// master drives events, slave (the scheduler) returns ev_ready.
interface voice_scheduler_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [6:0] ev_note;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_note,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_note,
    output ev_ready
  );
endinterface

// File: rtl/voice_alloc.sv
// Priority encoder over the voice table: lowest held voice with
// the event note, else lowest free voice.
module voice_alloc
  import voice_scheduler_pkg::*;
#(
  parameter int N  = NUM_VOICES_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]      key,
  input  logic [N-1:0][6:0] note,
  input  logic [6:0]        ev_note,
  output logic              match_found,
  output logic              free_found,
  output logic [IW-1:0]     slot
);

  logic [IW-1:0] match_idx;
  logic [IW-1:0] free_idx;

  // Scan downward so the lowest index is the last one written.
  always_comb begin
    match_found = 1'b0;
    free_found  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (key[i] && note[i] == ev_note) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!key[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    slot = match_found ? match_idx : free_idx;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice table with note-on/off allocation and a
// two-cycle-per-slot frame sweep toward the envelope engine.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  voice_scheduler_if.slave   ev,
  output logic [7:0]         voice_index,
  output logic               key_state,
  output logic [6:0]         voice_note,
  output logic               slot_phase,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               steal,
  output logic               tick_overrun
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  state_t state;
  state_t state_n;

  logic [IW-1:0]               slot;
  logic [IW-1:0]               steal_ptr;
  logic [IW-1:0]               alloc_slot;
  logic [NUM_VOICES-1:0]       key_q;
  logic [NUM_VOICES-1:0][6:0]  note_q;
  logic                        ev_on_q;
  logic [6:0]                  ev_note_q;
  logic                        match_found;
  logic                        free_found;
  logic                        accept;
  logic                        sweep_end;

  // Held off during the frame_done cycle too, so a waiting event
  // lands one cycle after the sweep finishes.
  assign ev.ev_ready = reset && state == IDLE
                    && !sample_tick && !frame_done;
  assign accept      = ev.ev_valid && ev.ev_ready;
  assign sweep_end   = state == SWEEP
                    && slot_phase == PH_COMPUTE
                    && slot == LAST;
  assign frame_busy  = state == SWEEP;
  assign voice_index = 8'(slot);

  voice_alloc #(
    .N  (NUM_VOICES),
    .IW (IW)
  ) u_alloc (
    .key         (key_q),
    .note        (note_q),
    .ev_note     (ev_note_q),
    .match_found (match_found),
    .free_found  (free_found),
    .slot        (alloc_slot)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (sample_tick) state_n = SWEEP;
        else if (accept) state_n = EVENT;
      end
      EVENT: state_n = IDLE;
      SWEEP: if (sweep_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot         <= '0;
      slot_phase   <= PH_READ;
      key_state    <= 1'b0;
      voice_note   <= '0;
      frame_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      frame_done   <= sweep_end;
      tick_overrun <= state == SWEEP && sample_tick;
      if (state == IDLE && sample_tick) begin
        slot       <= '0;
        slot_phase <= PH_READ;
        key_state  <= key_q[0];
        voice_note <= note_q[0];
      end else if (sweep_end) begin
        slot       <= '0;
        slot_phase <= PH_READ;
        key_state  <= 1'b0;
        voice_note <= '0;
      end else if (state == SWEEP) begin
        if (slot_phase == PH_READ) begin
          slot_phase <= PH_COMPUTE;
        end else begin
          slot       <= slot + 1'b1;
          slot_phase <= PH_READ;
          key_state  <= key_q[slot + 1'b1];
          voice_note <= note_q[slot + 1'b1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= '0;
      note_q    <= '0;
      steal_ptr <= '0;
      steal     <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
    end else begin
      steal <= 1'b0;
      if (accept) begin
        ev_on_q   <= ev.ev_on;
        ev_note_q <= ev.ev_note;
      end
      if (state == EVENT) begin
        if (ev_on_q) begin
          if (match_found || free_found) begin
            key_q[alloc_slot]  <= 1'b1;
            note_q[alloc_slot] <= ev_note_q;
          end else begin
            key_q[steal_ptr]  <= 1'b1;
            note_q[steal_ptr] <= ev_note_q;
            steal             <= 1'b1;
            steal_ptr         <= (steal_ptr == LAST)
                               ? '0 : steal_ptr + 1'b1;
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (key_q[i] && note_q[i] == ev_note_q)
              key_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler against a behavioural
// voice-table model; directed scenarios plus random event streams.
module tb_voice_scheduler;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] voice_index;
  logic       key_state;
  logic [6:0] voice_note;
  logic       slot_phase;
  logic       frame_busy;
  logic       frame_done;
  logic       steal;
  logic       tick_overrun;

  voice_scheduler_if ev_bus ();

  voice_scheduler #(.NUM_VOICES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .ev           (ev_bus),
    .voice_index  (voice_index),
    .key_state    (key_state),
    .voice_note   (voice_note),
    .slot_phase   (slot_phase),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .steal        (steal),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int steal_cnt = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (steal)        steal_cnt <= steal_cnt + 1;
    if (frame_done)   done_cnt  <= done_cnt + 1;
    if (tick_overrun) ovr_cnt   <= ovr_cnt + 1;
  end

  bit         m_key [N];
  logic [6:0] m_note[N];
  int         m_sp;
  int         exp_steals = 0;
  bit         o_key [N];
  logic [6:0] o_note[N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_key[i]  = 1'b0;
      m_note[i] = 7'd0;
    end
    m_sp = 0;
  endfunction

  function automatic void model_apply(bit on, logic [6:0] n);
    if (on) begin
      for (int i = 0; i < N; i++)
        if (m_key[i] && m_note[i] == n) return;
      for (int i = 0; i < N; i++)
        if (!m_key[i]) begin
          m_key[i]  = 1'b1;
          m_note[i] = n;
          return;
        end
      m_key[m_sp]  = 1'b1;
      m_note[m_sp] = n;
      m_sp = (m_sp + 1) % N;
      exp_steals++;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_key[i] && m_note[i] == n) m_key[i] = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    ev_bus.ev_valid = 1'b0;
    sample_tick = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
  endtask

  task automatic send_ev(input bit on, input logic [6:0] n);
    int w;
    w = 0;
    ev_bus.ev_valid = 1'b1;
    ev_bus.ev_on = on;
    ev_bus.ev_note = n;
    while (!ev_bus.ev_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ev_accept: ev_ready stuck at %0b, need 1",
               ev_bus.ev_ready);
      ev_bus.ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ev_bus.ev_valid = 1'b0;
    model_apply(on, n);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_sweep(input string tag);
    logic [18:0] obs;
    logic [18:0] exp;
    int idx;
    bit ph;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int c = 1; c <= 2 * N + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * N) begin
        idx = (c - 1) / 2;
        ph = bit'((c - 1) % 2);
        exp = {8'(idx), ph, m_key[idx], m_note[idx], 1'b1, 1'b0};
        obs = {voice_index, slot_phase, key_state, voice_note,
               frame_busy, frame_done};
        if (!ph) begin
          o_key[idx]  = key_state;
          o_note[idx] = voice_note;
        end
      end else begin
        exp = {8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1};
        obs = {voice_index, slot_phase, 1'b0, 7'd0,
               frame_busy, frame_done};
      end
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sweep_%s c%0d: got %h need %h", tag, c, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    reset = 1'b0;
    ev_bus.ev_valid = 1'b1;
    ev_bus.ev_on = 1'b1;
    ev_bus.ev_note = 7'd10;
    repeat (2) @(negedge clk);
    #1;
    obs = {voice_index, slot_phase, key_state, voice_note, frame_busy,
           frame_done, steal, tick_overrun, ev_bus.ev_ready};
    n_cmp++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h need 0", obs);
    end
    ev_bus.ev_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (ev_bus.ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b need 1", ev_bus.ev_ready);
    end
  endtask

  task automatic test_empty_sweep();
    int d0;
    d0 = done_cnt;
    run_sweep("empty");
    @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d need 1", done_cnt - d0);
    end
  endtask

  task automatic test_note_on();
    logic [16:0] obs;
    bit rest;
    do_reset();
    send_ev(1'b1, 7'd60);
    send_ev(1'b1, 7'd64);
    run_sweep("noteon");
    rest = 1'b0;
    for (int i = 2; i < N; i++) rest = rest | o_key[i];
    obs = {o_key[0], o_note[0], o_key[1], o_note[1], rest};
    n_cmp++;
    if (obs !== {1'b1, 7'd60, 1'b1, 7'd64, 1'b0}) begin
      n_fail++;
      $display("FAIL note_on_table: got %h need %h", obs,
               {1'b1, 7'd60, 1'b1, 7'd64, 1'b0});
    end
  endtask

  task automatic test_steal();
    int s0;
    s0 = steal_cnt;
    do_reset();
    for (int k = 0; k < N; k++) send_ev(1'b1, 7'(40 + k));
    n_cmp++;
    if (steal_cnt - s0 !== 0) begin
      n_fail++;
      $display("FAIL steal_early: got %0d need 0", steal_cnt - s0);
    end
    send_ev(1'b1, 7'd56);
    n_cmp++;
    if (steal_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL steal_first: got %0d need 1", steal_cnt - s0);
    end
    run_sweep("steal1");
    n_cmp++;
    if ({o_note[0], o_note[1], o_note[15]} !== {7'd56, 7'd41, 7'd55}) begin
      n_fail++;
      $display("FAIL steal_v0: got %0d/%0d/%0d need 56/41/55",
               o_note[0], o_note[1], o_note[15]);
    end
    send_ev(1'b1, 7'd57);
    n_cmp++;
    if (steal_cnt - s0 !== 2) begin
      n_fail++;
      $display("FAIL steal_second: got %0d need 2", steal_cnt - s0);
    end
    run_sweep("steal2");
    n_cmp++;
    if ({o_note[0], o_note[1], o_note[2]} !== {7'd56, 7'd57, 7'd42}) begin
      n_fail++;
      $display("FAIL steal_v1: got %0d/%0d/%0d need 56/57/42",
               o_note[0], o_note[1], o_note[2]);
    end
  endtask

  task automatic test_dup_off();
    do_reset();
    send_ev(1'b1, 7'd60);
    send_ev(1'b1, 7'd60);
    run_sweep("dup");
    n_cmp++;
    if ({o_key[0], o_note[0], o_key[1]} !== {1'b1, 7'd60, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_once: got %b/%0d/%b need 1/60/0",
               o_key[0], o_note[0], o_key[1]);
    end
    send_ev(1'b0, 7'd60);
    send_ev(1'b0, 7'd99);
    run_sweep("off");
    n_cmp++;
    if (o_key[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL note_off: got %b need 0", o_key[0]);
    end
    send_ev(1'b1, 7'd70);
    run_sweep("reuse");
    n_cmp++;
    if ({o_key[0], o_note[0], o_key[1]} !== {1'b1, 7'd70, 1'b0}) begin
      n_fail++;
      $display("FAIL reuse_v0: got %b/%0d/%b need 1/70/0",
               o_key[0], o_note[0], o_key[1]);
    end
  endtask

  task automatic test_tick_collision();
    int ready_c;
    int done_c;
    int ovr_c;
    int o0;
    bool_dummy: begin end
    ready_c = -1;
    done_c = -1;
    ovr_c = -1;
    do_reset();
    o0 = ovr_cnt;
    ev_bus.ev_valid = 1'b1;
    ev_bus.ev_on = 1'b1;
    ev_bus.ev_note = 7'd72;
    sample_tick = 1'b1;
    #1;
    n_cmp++;
    if (ev_bus.ev_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_priority: got %b need 0", ev_bus.ev_ready);
    end
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 10) sample_tick = 1'b1;
      if (c == 11) sample_tick = 1'b0;
      #1;
      if (frame_done && done_c < 0) done_c = c;
      if (tick_overrun && ovr_c < 0) ovr_c = c;
      if (ev_bus.ev_ready) begin
        ready_c = c;
        @(posedge clk);
        #1 ev_bus.ev_valid = 1'b0;
        model_apply(1'b1, 7'd72);
        break;
      end
    end
    ev_bus.ev_valid = 1'b0;
    n_cmp++;
    if ({done_c, ready_c, ovr_c} !== {32'd33, 32'd34, 32'd11}) begin
      n_fail++;
      $display("FAIL collide_timing: done %0d ready %0d ovr %0d need 33 34 11",
               done_c, ready_c, ovr_c);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (ovr_cnt - o0 !== 1) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d need 1", ovr_cnt - o0);
    end
    run_sweep("late_ev");
    n_cmp++;
    if ({o_key[0], o_note[0]} !== {1'b1, 7'd72}) begin
      n_fail++;
      $display("FAIL late_event: got %b/%0d need 1/72", o_key[0], o_note[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] obs;
    int d0;
    do_reset();
    send_ev(1'b1, 7'd60);
    send_ev(1'b1, 7'd61);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if ({voice_index, slot_phase} !== {8'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_slot: got %0d/%b need 7/0", voice_index, slot_phase);
    end
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    obs = {voice_index, slot_phase, key_state, voice_note, frame_busy,
           frame_done, steal, tick_overrun};
    n_cmp++;
    if (obs !== 22'd0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got %h need 0", obs);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (40) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d need %0d", done_cnt, d0);
    end
    run_sweep("cleared");
  endtask

  task automatic test_random();
    int s0;
    int e0;
    s0 = steal_cnt;
    do_reset();
    e0 = exp_steals;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++)
        send_ev($urandom_range(0, 9) < 7, 7'($urandom_range(40, 60)));
      run_sweep("rand");
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (steal_cnt - s0 !== exp_steals - e0) begin
      n_fail++;
      $display("FAIL rand_steals: got %0d need %0d",
               steal_cnt - s0, exp_steals - e0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_bus.ev_valid = 1'b0;
    ev_bus.ev_on = 1'b0;
    ev_bus.ev_note = 7'd0;
    model_reset();
    test_reset();
    test_empty_sweep();
    test_note_on();
    test_steal();
    test_dup_off();
    test_tick_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter: NUM_VOICES, 16, number of voice slots swept per frame (2..256).
REQ-002 SHALL have port: clk  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: sample_tick  input  1  one-cycle strobe starting a frame sweep.
REQ-005 SHALL have port: ev_valid  input  1  note event offered.
REQ-006 SHALL have port: ev_ready  output  1  note event accepted when ev_valid and ev_ready are both high.
REQ-007 SHALL have port: ev_on  input  1  1=note-on, 0=note-off.
REQ-008 SHALL have port: ev_note  input  7  MIDI note number.
REQ-009 SHALL have port: voice_index  output  8  slot presented to the envelope engine.
REQ-010 SHALL have port: key_state  output  1  key state of voice_index.
REQ-011 SHALL have port: voice_note  output  7  note held by voice_index.
REQ-012 SHALL have port: slot_phase  output  1  0=read cycle, 1=compute cycle.
REQ-013 SHALL have port: frame_busy  output  1  high during a sweep.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse after the last slot.
REQ-015 SHALL have port: steal  output  1  one-cycle pulse when a note-on evicts an active voice.
REQ-016 SHALL have port: tick_overrun  output  1  one-cycle pulse when sample_tick arrives during a sweep.

Function
REQ-017 SHALL implement FSM states IDLE, EVENT and SWEEP.
REQ-018 SHALL keep per-voice state: key (1 bit) and note (7 bits).
REQ-019 SHALL enter SWEEP from IDLE on sample_tick; sample_tick has priority over a same-cycle event, so ev_ready is low that cycle.
REQ-020 SHALL, in SWEEP, hold each voice_index for exactly 2 cycles (slot_phase 0 then 1), voices 0..NUM_VOICES-1 in order; one sweep is 2*NUM_VOICES cycles.
REQ-021 SHALL present key_state and voice_note registered and aligned with voice_index, stable for both phases.
REQ-022 SHALL pulse frame_done in the cycle after the phase-1 cycle of slot NUM_VOICES-1, return to IDLE that cycle, and drive voice_index to 0 there.
REQ-023 SHALL ignore sample_tick during SWEEP, pulse tick_overrun, and neither restart nor extend the sweep.
REQ-024 SHALL drive ev_ready high only in IDLE with sample_tick low.
REQ-025 SHALL, on acceptance, go to EVENT for exactly 1 cycle (ev_ready low), apply the event, then return to IDLE.
REQ-026 SHALL, for note-on where a voice already has key=1 with the same note, change nothing.
REQ-027 SHALL otherwise assign note-on to the lowest-index voice with key=0, setting key=1 and note=ev_note.
REQ-028 SHALL, if no voice is free, overwrite voice steal_ptr (key=1, note=ev_note), pulse steal, and advance steal_ptr modulo NUM_VOICES.
REQ-029 SHALL, for note-off, clear key on every voice with key=1 and a matching note; with no match there is no change and no error.
REQ-030 SHALL never change the voice table during SWEEP; events wait in IDLE via backpressure.
REQ-031 SHALL make event table updates visible on the next sweep.

Reset
REQ-032 SHALL, while reset is low, force state IDLE, all key=0, all note=0, steal_ptr=0, voice_index=0, slot_phase=0, key_state=0, voice_note=0, and frame_busy, frame_done, steal and tick_overrun=0; ev_ready=0 while reset is asserted.
REQ-033 SHALL, on reset mid-sweep, abandon the sweep immediately with no frame_done, and on release start in IDLE.

Structure
REQ-034 SHALL place the FSM state encoding, the NUM_VOICES default and the slot-phase constants in the shared synth package.
REQ-035 SHALL implement free-voice and matching-note search in one sub-module, voice_alloc: a combinational priority encoder returning found flag and lowest index.

Verification
REQ-036 SHALL test: reset, then sample_tick -> voice_index 0..15 each held 2 cycles, key_state 0 throughout, frame_done at cycle 33 after tick.
REQ-037 SHALL test: note-on 60, then 64, then tick -> voice0 note 60 key 1, voice1 note 64 key 1, others key 0.
REQ-038 SHALL test: 17 note-ons 40..56 -> voices 0..15 hold 40..55; note 56 overwrites voice 0 with steal pulse; next steal hits voice 1.
REQ-039 SHALL test: note-on 60 twice, then note-off 60 -> only one voice used; after note-off, key=0 on that voice; a later note-on 70 reuses voice 0.
REQ-040 SHALL test: event offered with sample_tick in the same cycle -> ev_ready 0, sweep completes, event accepted the cycle after frame_done; second tick mid-sweep -> tick_overrun pulse, sweep length unchanged.
REQ-041 SHALL test: reset asserted at slot 7 -> outputs zero immediately, no frame_done, table cleared.
